// File: rtl/edge_scan_lr_if.sv
// Request/result handshake and pixel memory read port of the left/right edge finder.
// master = requester side (also supplies memory read data); slave = the edge finder.
interface edge_scan_lr_if #(
  parameter int X_SZ    = 3,
  parameter int Y_SZ    = 3,
  parameter int ADDR_SZ = 6,
  parameter int COL_SZ  = 3
) ();
  logic                start;
  logic [Y_SZ-1:0]     mostTop;
  logic [Y_SZ-1:0]     mostBottom;
  logic [X_SZ-1:0]     midPix;
  logic [ADDR_SZ-1:0]  mem_addr;
  logic                mem_rd;
  logic [COL_SZ-1:0]   mem_q;
  logic                busy;
  logic                done;
  logic                found;
  logic                err;
  logic [X_SZ-1:0]     mostLeft;
  logic [X_SZ-1:0]     mostRight;

  modport master (
    output start, mostTop, mostBottom, midPix, mem_q,
    input  mem_addr, mem_rd, busy, done, found, err, mostLeft, mostRight
  );

  modport slave (
    input  start, mostTop, mostBottom, midPix, mem_q,
    output mem_addr, mem_rd, busy, done, found, err, mostLeft, mostRight
  );
endinterface

// File: rtl/edge_scan_lr.sv
// Left/right extent finder: for every row in [mostTop, mostBottom] it walks right
// from midPix, then left from midPix-1, through a single read port with fixed
// read latency, and accumulates the widest foreground extent seen.
module edge_scan_lr #(
  parameter int IMG_W     = 6,
  parameter int IMG_H     = 6,
  parameter int X_SZ      = 3,
  parameter int Y_SZ      = 3,
  parameter int ADDR_SZ   = 6,
  parameter int COL_SZ    = 3,
  parameter int THRESHOLD = 0,
  parameter int RD_LAT    = 1
) (
  input logic           clk,
  input logic           reset,
  edge_scan_lr_if.slave bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_R_ISSUE  = 3'd2;
  localparam logic [2:0] S_R_WAIT   = 3'd3;
  localparam logic [2:0] S_L_ISSUE  = 3'd4;
  localparam logic [2:0] S_L_WAIT   = 3'd5;
  localparam logic [2:0] S_NEXT_ROW = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam int               CNT_SZ   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_SZ-1:0] CNT_LAST = CNT_SZ'(RD_LAT - 1);
  localparam logic [CNT_SZ-1:0] CNT_ONE  = CNT_SZ'(1);
  localparam logic [X_SZ-1:0]   X_LAST   = X_SZ'(IMG_W - 1);
  localparam logic [X_SZ-1:0]   X_ONE    = X_SZ'(1);
  localparam logic [Y_SZ-1:0]   Y_ONE    = Y_SZ'(1);
  localparam logic [COL_SZ-1:0] BG       = COL_SZ'(THRESHOLD);
  localparam logic [31:0]       IMG_W_U  = IMG_W;
  localparam logic [31:0]       IMG_H_U  = IMG_H;

  logic [2:0]        state_q, state_d;
  logic [Y_SZ-1:0]   top_q, top_d, bot_q, bot_d, y_q, y_d;
  logic [X_SZ-1:0]   mid_q, mid_d, x_q, x_d;
  logic [CNT_SZ-1:0] cnt_q, cnt_d;
  logic [X_SZ-1:0]   acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic              any_fg_q, any_fg_d;
  logic              busy_q, busy_d, done_q, done_d, found_q, found_d, err_q, err_d;
  logic [X_SZ-1:0]   left_q, left_d, right_q, right_d;

  logic              fg, last_wait, finish, finish_err, invalid;
  logic [X_SZ-1:0]   row_right, row_left;

  // Next-state, scan cursor and accumulator update
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    bot_d     = bot_q;
    mid_d     = mid_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    any_fg_d  = any_fg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    err_d     = err_q;
    left_d    = left_q;
    right_d   = right_q;
    finish     = 1'b0;
    finish_err = 1'b0;
    fg        = (bus.mem_q != BG);
    last_wait = (cnt_q == CNT_LAST);
    // Edge column if the current pixel terminates the walk
    row_right = fg ? X_LAST : (x_q - X_ONE);
    row_left  = fg ? '0 : (x_q + X_ONE);
    invalid   = (top_q > bot_q) || (32'(bot_q) >= IMG_H_U) || (32'(mid_q) >= IMG_W_U);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          top_d   = bus.mostTop;
          bot_d   = bus.mostBottom;
          mid_d   = bus.midPix;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (invalid) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          y_d       = top_q;
          x_d       = mid_q;
          acc_min_d = X_LAST;
          acc_max_d = '0;
          any_fg_d  = 1'b0;
          state_d   = S_R_ISSUE;
        end
      end
      S_R_ISSUE: begin
        cnt_d   = '0;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (!last_wait) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (!fg && (x_q == mid_q)) begin
          // Background seed: row contributes nothing, left walk skipped
          state_d = S_NEXT_ROW;
        end else if (fg && (x_q < X_LAST)) begin
          x_d     = x_q + X_ONE;
          state_d = S_R_ISSUE;
        end else begin
          any_fg_d = 1'b1;
          if (row_right > acc_max_q) acc_max_d = row_right;
          if (mid_q == '0) begin
            // Seed sits on the left border, nothing to walk
            acc_min_d = '0;
            state_d   = S_NEXT_ROW;
          end else begin
            x_d     = mid_q - X_ONE;
            state_d = S_L_ISSUE;
          end
        end
      end
      S_L_ISSUE: begin
        cnt_d   = '0;
        state_d = S_L_WAIT;
      end
      S_L_WAIT: begin
        if (!last_wait) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (fg && (x_q != '0)) begin
          x_d     = x_q - X_ONE;
          state_d = S_L_ISSUE;
        end else begin
          if (row_left < acc_min_q) acc_min_d = row_left;
          state_d = S_NEXT_ROW;
        end
      end
      S_NEXT_ROW: begin
        // Compare before incrementing so y never wraps at the top of its range
        if (y_q == bot_q) begin
          finish = 1'b1;
        end else begin
          y_d     = y_q + Y_ONE;
          x_d     = mid_q;
          state_d = S_R_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Publish results on the edge into DONE so they are visible with the done pulse
    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = finish_err;
      found_d = any_fg_q & ~finish_err;
      left_d  = found_d ? acc_min_q : '0;
      right_d = found_d ? acc_max_q : '0;
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      top_q     <= '0;
      bot_q     <= '0;
      mid_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      any_fg_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      state_q   <= state_d;
      top_q     <= top_d;
      bot_q     <= bot_d;
      mid_q     <= mid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      any_fg_q  <= any_fg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      err_q     <= err_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  logic issuing;
  assign issuing      = (state_q == S_R_ISSUE) || (state_q == S_L_ISSUE);
  assign bus.mem_rd   = issuing;
  assign bus.mem_addr = issuing ? (ADDR_SZ'(y_q) * ADDR_SZ'(IMG_W) + ADDR_SZ'(x_q)) : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.err       = err_q;
  assign bus.mostLeft  = left_q;
  assign bus.mostRight = right_q;
endmodule

// File: tb/tb_edge_scan_lr.sv
// Directed bench: two finders (read latency 1 and 2) share one 6x6 image memory model.
module tb_edge_scan_lr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, start0, start1;
  logic [2:0] top_i, bot_i, mid_i;
  logic [2:0] img [0:35];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  int         cur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  edge_scan_lr_if #(.X_SZ(3), .Y_SZ(3), .ADDR_SZ(6), .COL_SZ(3)) bus0 ();
  edge_scan_lr_if #(.X_SZ(3), .Y_SZ(3), .ADDR_SZ(6), .COL_SZ(3)) bus1 ();

  edge_scan_lr #(.RD_LAT(1)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  edge_scan_lr #(.RD_LAT(2)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  assign bus0.start = start0;
  assign bus0.mostTop = top_i;
  assign bus0.mostBottom = bot_i;
  assign bus0.midPix = mid_i;
  assign bus1.start = start1;
  assign bus1.mostTop = top_i;
  assign bus1.mostBottom = bot_i;
  assign bus1.midPix = mid_i;

  function automatic logic [2:0] rd(input logic [5:0] a);
    if (int'(a) < 36) return img[int'(a)];
    return 3'd0;
  endfunction

  // Memory model: data valid 1 cycle (dut0) / 2 cycles (dut1) after the address
  logic [2:0] q0, q1a, q1b;
  always @(posedge clk) begin
    q0  <= rd(bus0.mem_addr);
    q1a <= rd(bus1.mem_addr);
    q1b <= q1a;
  end
  assign bus0.mem_q = q0;
  assign bus1.mem_q = q1b;

  // Read log from both ports
  int rd_addr[$];
  int rd_cyc[$];
  always @(posedge clk) begin
    if (bus0.mem_rd) begin rd_addr.push_back(int'(bus0.mem_addr)); rd_cyc.push_back(cyc); end
    if (bus1.mem_rd) begin rd_addr.push_back(int'(bus1.mem_addr)); rd_cyc.push_back(cyc); end
  end

  logic o_busy, o_done, o_found, o_err, o_rd;
  logic [2:0] o_left, o_right;
  logic [5:0] o_addr;
  always_comb begin
    if (cur == 1) begin
      o_busy = bus1.busy; o_done = bus1.done; o_found = bus1.found; o_err = bus1.err;
      o_left = bus1.mostLeft; o_right = bus1.mostRight; o_rd = bus1.mem_rd; o_addr = bus1.mem_addr;
    end else begin
      o_busy = bus0.busy; o_done = bus0.done; o_found = bus0.found; o_err = bus0.err;
      o_left = bus0.mostLeft; o_right = bus0.mostRight; o_rd = bus0.mem_rd; o_addr = bus0.mem_addr;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_found"}, int'(o_found), 0);
    check({tag, "_err"}, int'(o_err), 0);
    check({tag, "_left"}, int'(o_left), 0);
    check({tag, "_right"}, int'(o_right), 0);
    check({tag, "_mem_rd"}, int'(o_rd), 0);
    check({tag, "_mem_addr"}, int'(o_addr), 0);
  endtask

  task automatic set_row(input int y, input int lo, input int hi);
    for (int x = lo; x <= hi; x++) img[y*6 + x] = 3'(x + 1);
  endtask

  task automatic load_shape(input int id);
    for (int i = 0; i < 36; i++) img[i] = 3'd0;
    case (id)
      1: for (int y = 1; y <= 3; y++) set_row(y, 1, 4);
      2: set_row(2, 0, 5);
      3: begin set_row(0, 2, 3); set_row(1, 0, 4); set_row(2, 1, 5); end
      4: begin set_row(0, 1, 3); set_row(2, 1, 3); img[6] = 3'd5; img[10] = 3'd5; end
      default: ;
    endcase
  endtask

  // Starts a scan and returns at the negedge where done is seen (lat=-1 on timeout).
  // poke_at >= 0 re-asserts start with other inputs while the scan is running.
  task automatic run_scan(input int sel, input int t, input int b, input int m,
                          input int poke_at, output int lat);
    int c0;
    cur = sel;
    @(negedge clk);
    rd_addr.delete();
    rd_cyc.delete();
    top_i = 3'(t); bot_i = 3'(b); mid_i = 3'(m);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    c0  = cyc;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (k == 0) check("busy_after_start", int'(o_busy), 1);
      if (k == poke_at) begin
        top_i = 3'd2; bot_i = 3'd2; mid_i = 3'd0;
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
      end
      if (o_done) begin lat = cyc - c0; break; end
    end
  endtask

  typedef struct {
    int sel, shape, top, bot, mid;
    int err, found, left, right, nreads, lat, gap;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, gap, exp_a, quiet_done;
    vecs[0]  = '{0, 1, 1, 3, 2, 0, 1, 1, 4, 18, 41, 2};
    vecs[1]  = '{0, 2, 2, 2, 3, 0, 1, 0, 5,  6, 15, 2};
    vecs[2]  = '{0, 2, 2, 2, 0, 0, 1, 0, 5,  6, 15, 2};
    vecs[3]  = '{0, 2, 2, 2, 5, 0, 1, 0, 5,  6, 15, 2};
    vecs[4]  = '{0, 3, 0, 2, 2, 0, 1, 0, 5, 16, 37, 2};
    vecs[5]  = '{0, 4, 0, 2, 2, 0, 1, 1, 3, 11, 27, 2};
    vecs[6]  = '{0, 1, 4, 2, 2, 1, 0, 0, 0,  0,  2, 0};
    vecs[7]  = '{0, 1, 0, 1, 6, 1, 0, 0, 0,  0,  2, 0};
    vecs[8]  = '{0, 1, 0, 6, 2, 1, 0, 0, 0,  0,  2, 0};
    vecs[9]  = '{0, 0, 0, 5, 2, 0, 0, 0, 0,  6, 20, 3};
    vecs[10] = '{1, 1, 1, 3, 2, 0, 1, 1, 4, 18, 59, 3};
    vecs[11] = '{1, 3, 0, 2, 2, 0, 1, 0, 5, 16, 53, 3};

    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    top_i = '0; bot_i = '0; mid_i = '0;
    load_shape(0);
    repeat (3) @(negedge clk);
    cur = 0; #1 check_idle_outputs("reset0");
    cur = 1; #1 check_idle_outputs("reset1");
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven scans
    foreach (vecs[i]) begin
      load_shape(vecs[i].shape);
      run_scan(vecs[i].sel, vecs[i].top, vecs[i].bot, vecs[i].mid, -1, lat);
      check("latency", lat, vecs[i].lat);
      check("err", int'(o_err), vecs[i].err);
      check("found", int'(o_found), vecs[i].found);
      check("mostLeft", int'(o_left), vecs[i].left);
      check("mostRight", int'(o_right), vecs[i].right);
      check("busy_in_done", int'(o_busy), 0);
      check("read_count", rd_addr.size(), vecs[i].nreads);
      if (vecs[i].gap != 0) begin
        gap = 1000;
        for (int k = 1; k < rd_cyc.size(); k++)
          if (rd_cyc[k] - rd_cyc[k-1] < gap) gap = rd_cyc[k] - rd_cyc[k-1];
        check("read_gap", gap, vecs[i].gap);
      end
      $display("[TB] vec %0d dut%0d top=%0d bot=%0d mid=%0d -> lat=%0d err=%0d found=%0d L=%0d R=%0d reads=%0d",
               i, vecs[i].sel, vecs[i].top, vecs[i].bot, vecs[i].mid, lat,
               o_err, o_found, o_left, o_right, rd_addr.size());
      @(negedge clk);
      check("done_pulse_width", int'(o_done), 0);
    end

    // Exact address order for the rectangle scan
    load_shape(1);
    run_scan(0, 1, 3, 2, -1, lat);
    check("seq1_len", rd_addr.size(), 18);
    for (int y = 1; y <= 3; y++) begin
      int xs[6];
      xs = '{2, 3, 4, 5, 1, 0};
      for (int k = 0; k < 6; k++) begin
        exp_a = y*6 + xs[k];
        if ((y-1)*6 + k < rd_addr.size()) check("seq1_addr", rd_addr[(y-1)*6 + k], exp_a);
      end
    end
    $display("[TB] addr sequence rect x1..4 y1..3 mid2: %0d reads", rd_addr.size());

    // Full-width row: addresses stay inside the row at both borders
    load_shape(2);
    run_scan(0, 2, 2, 3, -1, lat);
    begin
      int exp_seq[6];
      exp_seq = '{15, 16, 17, 14, 13, 12};
      check("seq2_len", rd_addr.size(), 6);
      for (int k = 0; k < 6; k++)
        if (k < rd_addr.size()) check("seq2_addr", rd_addr[k], exp_seq[k]);
    end
    $display("[TB] addr sequence full row mid3: %0d reads", rd_addr.size());

    // start during the DONE cycle is ignored
    start0 = 1'b1; top_i = 3'd1; bot_i = 3'd3; mid_i = 3'd2;
    rd_addr.delete();
    @(negedge clk);
    start0 = 1'b0;
    check("done_cycle_start_busy", int'(o_busy), 0);
    repeat (3) @(negedge clk);
    check("done_cycle_start_busy_later", int'(o_busy), 0);
    check("done_cycle_start_reads", rd_addr.size(), 0);
    $display("[TB] start in DONE cycle: busy=%0d reads=%0d", o_busy, rd_addr.size());

    // start in the cycle right after DONE is accepted
    load_shape(2);
    run_scan(0, 2, 2, 3, -1, lat);
    run_scan(0, 2, 2, 0, -1, lat);
    check("back_to_back_lat", lat, 15);
    check("back_to_back_reads", rd_addr.size(), 6);
    $display("[TB] back-to-back start: lat=%0d reads=%0d", lat, rd_addr.size());

    // start while busy is ignored
    load_shape(1);
    run_scan(0, 1, 3, 2, 8, lat);
    check("busy_start_lat", lat, 41);
    check("busy_start_left", int'(o_left), 1);
    check("busy_start_right", int'(o_right), 4);
    check("busy_start_reads", rd_addr.size(), 18);
    $display("[TB] start while busy: lat=%0d L=%0d R=%0d reads=%0d", lat, o_left, o_right, rd_addr.size());
    @(negedge clk);
    check("busy_start_no_restart", int'(o_busy), 0);

    // Reset in the middle of a latency-2 scan
    cur = 1;
    @(negedge clk);
    top_i = 3'd1; bot_i = 3'd3; mid_i = 3'd2; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check_idle_outputs("midscan_reset");
    rd_addr.delete();
    quiet_done = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_done || o_busy) quiet_done++;
    end
    check("reset_no_partial_result", quiet_done, 0);
    check("reset_no_reads", rd_addr.size(), 0);
    $display("[TB] mid-scan reset: activity=%0d reads=%0d", quiet_done, rd_addr.size());
    run_scan(1, 1, 3, 2, -1, lat);
    check("after_reset_lat", lat, 59);
    check("after_reset_left", int'(o_left), 1);
    check("after_reset_right", int'(o_right), 4);
    $display("[TB] scan after reset: lat=%0d L=%0d R=%0d", lat, o_left, o_right);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", n_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/edge_scan_lr.md
Name: edge_scan_lr

Overview:
- Parametrised left/right edge finder for a stored shape.
- After the top/bottom search supplies mostTop, mostBottom and midPix, it scans every row in that range, first outward-right from midPix and then outward-left, through one shared read-only pixel memory port.
- It reports the extreme foreground columns, mostLeft and mostRight.
- It replaces the paired right/left finders with one FSM: one memory port, explicit read latency, border clamping and a start/done handshake.

Parameters:
- IMG_W, 6: image width in pixels.
- IMG_H, 6: image height in pixels.
- X_SZ, 3: x coordinate width; must satisfy 2^X_SZ >= IMG_W.
- Y_SZ, 3: y coordinate width; must satisfy 2^Y_SZ >= IMG_H.
- ADDR_SZ, 6: memory address width; must satisfy 2^ADDR_SZ >= IMG_W*IMG_H.
- COL_SZ, 3: pixel value width.
- THRESHOLD, 0: background pixel value. Any pixel value != THRESHOLD is foreground.
- RD_LAT, 1: memory read latency in cycles, >= 1.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request. Accepted only while busy=0.
- mostTop, input, Y_SZ: first row to scan. Latched on start.
- mostBottom, input, Y_SZ: last row to scan, inclusive. Latched on start.
- midPix, input, X_SZ: seed column for every row. Latched on start.
- mem_addr, output, ADDR_SZ: read address, y*IMG_W + x, computed at full width with zero extension.
- mem_rd, output, 1: read strobe.
- mem_q, input, COL_SZ: read data, valid RD_LAT cycles after mem_rd.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the result registers update.
- found, output, 1: at least one row had a foreground seed pixel.
- err, output, 1: the latched inputs were invalid.
- mostLeft, output, X_SZ: minimum left extent over all scanned rows.
- mostRight, output, X_SZ: maximum right extent over all scanned rows.

Behaviour:
- Reset values: busy, done, found, err, mem_rd, mem_addr, mostLeft and mostRight all 0; FSM in IDLE.
- A reset in any state aborts the scan the following cycle. No partial result is published.
- FSM states: IDLE, CHECK, R_ISSUE, R_WAIT, L_ISSUE, L_WAIT, NEXT_ROW, DONE.
- IDLE:
  - On start, latch the inputs and go to CHECK.
  - start while busy is ignored.
- CHECK:
  - Invalid if mostTop > mostBottom, mostBottom >= IMG_H, or midPix >= IMG_W.
  - If invalid, go to DONE with err=1, found=0 and no memory reads.
  - Otherwise set y=mostTop, x=midPix, accMin=IMG_W-1, accMax=0, anyFg=0, then go to R_ISSUE.
- Read timing:
  - Each *_ISSUE state lasts 1 cycle with mem_rd=1 and mem_addr=(x,y).
  - Each *_WAIT state lasts exactly RD_LAT cycles. mem_q is evaluated in the last WAIT cycle.
  - Each pixel therefore costs 1+RD_LAT cycles. At most one read is outstanding.
- Right scan:
  - Seed pixel (x == midPix) is background: the row contributes nothing. Go to NEXT_ROW; the left scan is skipped.
  - Foreground and x < IMG_W-1: set x=x+1 and go to R_ISSUE.
  - Foreground and x == IMG_W-1: rowRight=IMG_W-1.
  - Background at x > midPix: rowRight=x-1.
  - On either right-edge outcome: set anyFg=1, accMax=max(accMax,rowRight).
    - If midPix == 0: rowLeft=0, accMin=0, go to NEXT_ROW.
    - Otherwise set x=midPix-1 and go to L_ISSUE.
- Left scan:
  - Foreground and x > 0: set x=x-1 and go to L_ISSUE.
  - Foreground and x == 0: rowLeft=0.
  - Background: rowLeft=x+1.
  - On either left-edge outcome: accMin=min(accMin,rowLeft), go to NEXT_ROW.
- Border rule: no address with x >= IMG_W, x < 0 (wrap) or y > mostBottom is ever issued.
- NEXT_ROW (1 cycle):
  - If y == mostBottom, go to DONE. This also covers mostBottom == 2^Y_SZ-1, so y never wraps.
  - Otherwise set y=y+1, x=midPix, go to R_ISSUE.
- DONE (1 cycle):
  - done=1. found=anyFg.
  - If anyFg: mostLeft=accMin, mostRight=accMax. Otherwise both are 0.
  - busy drops in the same cycle. Return to IDLE.
- Result outputs hold until the next DONE or reset.
- A start in the DONE cycle is ignored. A start in the following cycle is accepted.

Test Plan:
1. 6x6 image, RD_LAT=1, foreground rectangle x=1..4, y=1..3; start with top=1, bottom=3, mid=2 -> per row, reads at x=2,3,4,5 then 1,0, spaced 2 cycles apart; done with found=1, mostLeft=1, mostRight=4, err=0.
2. Rectangle x=0..5, y=2..2, mid=3, top=bottom=2 -> reads x=3,4,5 then 2,1,0, with no address for x=6 or x=-1; mostLeft=0, mostRight=5.
3. Irregular shape with row extents y=0:[2,3], y=1:[0,4], y=2:[1,5]; mid=2, top=0, bottom=2 -> mostLeft=0, mostRight=5.
4. Seed pixel background on row 1 only (rows 0 and 2 are [1,3]) -> row 1 issues exactly one read; mostLeft=1, mostRight=3. All rows background -> found=0, mostLeft=mostRight=0.
5. top=4, bottom=2 -> done 2 cycles after start, err=1, mem_rd never asserted. Then mid=6 -> err=1.
6. RD_LAT=2: case 1 repeated -> reads spaced 3 cycles apart, same result. Reset asserted mid-scan -> next cycle all outputs are 0 and the FSM is in IDLE. start while busy -> ignored and no restart.
